// File: rtl/bilinear_pkg.sv
// bilinear_pkg: shared state encoding, per-pixel counter increments and source-coordinate clamping.
package bilinear_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP, S_MUL, S_WR, S_PAUSE, S_DONE
    } bl_state_t;
    localparam int FLOPS_PER_PIX = 8;
    localparam int RDS_PER_PIX = 4;
    typedef struct packed {
        logic [31:0] i;
        logic [31:0] i1;
        logic [31:0] f;
    } coord_t;
    // Integer/fraction split of pos*scale, pinned to the last source column/row at the edge.
    function automatic coord_t clamp_coord(input logic [31:0] pos, input logic [31:0] scale,
                                           input logic [31:0] dim, input int frac_w);
        coord_t r;
        logic [63:0] s, ip, lim, fr;
        s = {32'd0, pos} * {32'd0, scale};
        ip = s >> frac_w;
        fr = s & ((64'd1 << frac_w) - 64'd1);
        lim = {32'd0, dim} - 64'd1;
        r.i = ip >= lim ? lim[31:0] : ip[31:0];
        r.f = ip >= lim ? 32'd0 : fr[31:0];
        r.i1 = r.i + 32'(r.f != 32'd0);
        return r;
    endfunction
endpackage

// File: rtl/bilinear_interp_dp.sv
// bilinear_interp_dp: registered bilinear blend of four pixels with round-half-up and saturation.
module bilinear_interp_dp #(
    parameter int PIX_W = 8,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [PIX_W-1:0]  p00_i,
    input  logic [PIX_W-1:0]  p01_i,
    input  logic [PIX_W-1:0]  p10_i,
    input  logic [PIX_W-1:0]  p11_i,
    input  logic [FRAC_W-1:0] fx_i,
    input  logic [FRAC_W-1:0] fy_i,
    output logic [PIX_W-1:0]  pix_o
);
    localparam int TW = PIX_W + FRAC_W + 1;
    localparam int ACC_W = PIX_W + 2 * FRAC_W + 3;
    localparam logic [FRAC_W:0] W_ONE = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'({PIX_W{1'b1}});
    logic [FRAC_W:0] wfx, wfy;
    logic [TW-1:0] top, bot;
    logic [ACC_W-1:0] acc, q;
    always_comb begin
        wfx = W_ONE - {1'b0, fx_i};
        wfy = W_ONE - {1'b0, fy_i};
        top = TW'(p00_i) * TW'(wfx) + TW'(p01_i) * TW'(fx_i);
        bot = TW'(p10_i) * TW'(wfx) + TW'(p11_i) * TW'(fx_i);
        acc = ACC_W'(top) * ACC_W'(wfy) + ACC_W'(bot) * ACC_W'(fy_i) + (ACC_W'(1) << (2 * FRAC_W - 1));
        q = acc >> (2 * FRAC_W);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pix_o <= '0;
        else if (en_i) pix_o <= q > PIX_MAX ? PIX_MAX[PIX_W-1:0] : q[PIX_W-1:0];
endmodule

// File: rtl/bilinear_core_param.sv
// bilinear_core_param: sequential bilinear rescaler, one output pixel per 8 cycles, with step mode and perf counters.
module bilinear_core_param import bilinear_pkg::*; #(
    parameter int AW = 19,
    parameter int PIX_W = 8,
    parameter int DIM_W = 12,
    parameter int FRAC_W = 8,
    parameter int SCL_W = FRAC_W + 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             step_mode,
    input  logic             step,
    input  logic [DIM_W-1:0] cfg_in_w,
    input  logic [DIM_W-1:0] cfg_in_h,
    input  logic [DIM_W-1:0] cfg_out_w,
    input  logic [DIM_W-1:0] cfg_out_h,
    input  logic [SCL_W-1:0] cfg_inv_scale,
    input  logic [AW-1:0]    cfg_src_base,
    input  logic [AW-1:0]    cfg_dst_base,
    output logic [AW-1:0]    mem_raddr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             mem_we,
    output logic [AW-1:0]    mem_waddr,
    output logic [PIX_W-1:0] mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             paused,
    output logic [DIM_W-1:0] o_out_w,
    output logic [DIM_W-1:0] o_out_h,
    output logic [CNT_W-1:0] o_flop_count,
    output logic [CNT_W-1:0] o_mem_rd_count,
    output logic [CNT_W-1:0] o_mem_wr_count
);
    localparam logic [CNT_W-1:0] CMAX = '1;
    bl_state_t state_q, state_d;
    logic [DIM_W-1:0] in_w_q, in_h_q, out_w_q, out_h_q, x_q, y_q, xi_q, x1_q, yi_q, y1_q, row, col;
    logic [SCL_W-1:0] scale_q;
    logic [AW-1:0] src_q, dst_q, raddr_q, waddr_q;
    logic [FRAC_W-1:0] fx_q, fy_q;
    logic [PIX_W-1:0] p00_q, p01_q, p10_q, p11_q;
    logic [CNT_W-1:0] flop_q, rd_q, wr_q;
    logic [2*DIM_W-1:0] roff, woff;
    logic step_mode_q, accept, last_x, last, adv;
    coord_t cx, cy;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int b);
        return a > CMAX - CNT_W'(b) ? CMAX : a + CNT_W'(b);
    endfunction

    always_comb begin
        accept = start && !abort && (state_q == S_IDLE || state_q == S_DONE);
        last_x = x_q == out_w_q - 1'b1;
        last = last_x && y_q == out_h_q - 1'b1;
        cx = clamp_coord(32'(x_q), 32'(scale_q), 32'(in_w_q), FRAC_W);
        cy = clamp_coord(32'(y_q), 32'(scale_q), 32'(in_h_q), FRAC_W);
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (accept) state_d = (cfg_out_w == '0 || cfg_out_h == '0) ? S_DONE : S_CALC;
            S_CALC:  state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3:   state_d = S_CAP;
            S_CAP:   state_d = S_MUL;
            S_MUL:   state_d = S_WR;
            S_WR:    state_d = step_mode_q ? S_PAUSE : last ? S_DONE : S_CALC;
            S_PAUSE: if (step) state_d = last ? S_DONE : S_CALC;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
        // x/y advance only when leaving a finished pixel, so PAUSE still sees the pixel just written
        adv = state_d == S_CALC && (state_q == S_WR || state_q == S_PAUSE);
        row = (state_q == S_RD0 || state_q == S_RD1) ? yi_q : y1_q;
        col = (state_q == S_RD0 || state_q == S_RD2) ? xi_q : x1_q;
        roff = row * in_w_q;
        woff = y_q * out_w_q;
        mem_raddr = (state_q inside {S_RD0, S_RD1, S_RD2, S_RD3}) ? src_q + AW'(roff) + AW'(col) : raddr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            {in_w_q, in_h_q, out_w_q, out_h_q, x_q, y_q, xi_q, x1_q, yi_q, y1_q} <= '0;
            {scale_q, src_q, dst_q, raddr_q, waddr_q, fx_q, fy_q, step_mode_q} <= '0;
            {p00_q, p01_q, p10_q, p11_q, flop_q, rd_q, wr_q} <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= mem_raddr;
            if (accept) begin
                {in_w_q, in_h_q, out_w_q, out_h_q} <= {cfg_in_w, cfg_in_h, cfg_out_w, cfg_out_h};
                {scale_q, src_q, dst_q, step_mode_q} <= {cfg_inv_scale, cfg_src_base, cfg_dst_base, step_mode};
                {x_q, y_q, flop_q, rd_q, wr_q} <= '0;
            end
            if (state_q == S_CALC) begin
                {xi_q, x1_q, fx_q} <= {DIM_W'(cx.i), DIM_W'(cx.i1), FRAC_W'(cx.f)};
                {yi_q, y1_q, fy_q} <= {DIM_W'(cy.i), DIM_W'(cy.i1), FRAC_W'(cy.f)};
            end
            if (state_q == S_RD1) p00_q <= mem_rdata;
            if (state_q == S_RD2) p01_q <= mem_rdata;
            if (state_q == S_RD3) p10_q <= mem_rdata;
            if (state_q == S_CAP) p11_q <= mem_rdata;
            if (state_q == S_MUL) waddr_q <= dst_q + AW'(woff) + AW'(x_q);
            if (state_q == S_WR) begin
                flop_q <= sat_add(flop_q, FLOPS_PER_PIX);
                rd_q <= sat_add(rd_q, RDS_PER_PIX);
                wr_q <= sat_add(wr_q, 1);
            end
            if (adv) begin
                x_q <= last_x ? '0 : x_q + 1'b1;
                y_q <= last_x ? y_q + 1'b1 : y_q;
            end
        end
    end

    bilinear_interp_dp #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) u_dp (
        .clk(clk), .rst_n(rst_n), .en_i(state_q == S_MUL),
        .p00_i(p00_q), .p01_i(p01_q), .p10_i(p10_q), .p11_i(p11_q),
        .fx_i(fx_q), .fy_i(fy_q), .pix_o(mem_wdata)
    );

    assign busy = !(state_q == S_IDLE || state_q == S_DONE);
    assign done = state_q == S_DONE;
    assign paused = state_q == S_PAUSE;
    assign mem_we = state_q == S_WR;
    assign mem_waddr = waddr_q;
    assign o_out_w = out_w_q;
    assign o_out_h = out_h_q;
    assign o_flop_count = flop_q;
    assign o_mem_rd_count = rd_q;
    assign o_mem_wr_count = wr_q;
endmodule

// File: tb/tb_bilinear_core_param.sv
// tb_bilinear_core_param: directed checks of the bilinear core against hand-computed pixels, timing and counters.
module tb_bilinear_core_param;
    localparam int AW = 19, PIX_W = 8, DIM_W = 12, SCL_W = 16, CNT_W = 32;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, step_mode = 0, step = 0;
    logic [DIM_W-1:0] cfg_in_w = '0, cfg_in_h = '0, cfg_out_w = '0, cfg_out_h = '0;
    logic [SCL_W-1:0] cfg_inv_scale = '0;
    logic [AW-1:0] cfg_src_base = '0, cfg_dst_base = '0;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [PIX_W-1:0] mem_rdata = '0, mem_wdata;
    logic mem_we, busy, done, paused;
    logic [DIM_W-1:0] o_out_w, o_out_h;
    logic [CNT_W-1:0] o_flop_count, o_mem_rd_count, o_mem_wr_count;
    logic [7:0] src_mem [0:(1<<AW)-1];
    logic [7:0] dst_mem [0:(1<<AW)-1];
    int n_tests = 0, n_fail = 0, we_cnt = 0;
    int dcyc, fwe, base, errs, steps;

    always #5 clk = ~clk;

    bilinear_core_param dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .step_mode(step_mode), .step(step),
        .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h),
        .cfg_inv_scale(cfg_inv_scale), .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .paused(paused),
        .o_out_w(o_out_w), .o_out_h(o_out_h), .o_flop_count(o_flop_count),
        .o_mem_rd_count(o_mem_rd_count), .o_mem_wr_count(o_mem_wr_count)
    );

    always @(posedge clk) mem_rdata <= src_mem[mem_raddr];
    always @(posedge clk) if (mem_we) begin
        dst_mem[mem_waddr] <= mem_wdata;
        we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg(input int iw, input int ih, input int ow, input int oh, input int scl,
                       input int sb, input int db, input logic sm);
        cfg_in_w = DIM_W'(iw); cfg_in_h = DIM_W'(ih); cfg_out_w = DIM_W'(ow); cfg_out_h = DIM_W'(oh);
        cfg_inv_scale = SCL_W'(scl); cfg_src_base = AW'(sb); cfg_dst_base = AW'(db); step_mode = sm;
    endtask

    // Pulse start, then scramble the config so the frame can only use latched values.
    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        cfg_in_w = ~cfg_in_w; cfg_out_w = ~cfg_out_w; cfg_out_h = ~cfg_out_h;
        cfg_inv_scale = ~cfg_inv_scale; cfg_src_base = ~cfg_src_base; cfg_dst_base = ~cfg_dst_base;
        step_mode = ~step_mode;
    endtask

    // Cycle numbers count from 1 = the cycle right after the start edge.
    task automatic run(output int done_cyc, output int first_we);
        pulse_start();
        done_cyc = -1; first_we = -1;
        for (int n = 1; n < 40000; n++) begin
            if (mem_we && first_we < 0) first_we = n;
            if (done) begin done_cyc = n; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        src_mem[0] = 8'd0; src_mem[1] = 8'd100; src_mem[2] = 8'd200; src_mem[3] = 8'd255;
        for (int i = 0; i < 4096; i++) src_mem['h2000 + i] = 8'((i * 7 + 3) & 255);
        #2;
        check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_paused", paused, 0);
        check("rst_we", mem_we, 0); check("rst_raddr", mem_raddr, 0); check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0); check("rst_flops", o_flop_count, 0); check("rst_outw", o_out_w, 0);
        @(negedge clk) rst_n = 1;

        cfg(2, 2, 4, 4, 'h80, 0, 'h1000, 0);
        base = we_cnt;
        run(dcyc, fwe);
        check("up_done_cyc", dcyc, 129); check("up_first_we", fwe, 8);
        check("up_flops", o_flop_count, 128); check("up_rd", o_mem_rd_count, 64);
        check("up_wr", o_mem_wr_count, 16); check("up_we_pulses", we_cnt - base, 16);
        check("up_busy", busy, 0); check("up_outw", o_out_w, 4); check("up_outh", o_out_h, 4);
        check("up_p00", dst_mem['h1000], 0); check("up_p10", dst_mem['h1001], 50);
        check("up_p01", dst_mem['h1004], 100); check("up_p11", dst_mem['h1005], 139);
        check("up_p21", dst_mem['h1006], 178); check("up_p33", dst_mem['h100f], 255);

        cfg(64, 64, 64, 64, 'h100, 'h2000, 'h10000, 0);
        run(dcyc, fwe);
        errs = 0;
        for (int i = 0; i < 4096; i++) if (dst_mem['h10000 + i] !== 8'((i * 7 + 3) & 255)) errs++;
        check("id_pixels", errs, 0); check("id_done_cyc", dcyc, 32769);
        check("id_wr", o_mem_wr_count, 4096); check("id_flops", o_flop_count, 32768);

        cfg(2, 2, 0, 4, 'h80, 0, 'h1000, 0);
        base = we_cnt;
        run(dcyc, fwe);
        check("zero_done_cyc", dcyc, 1); check("zero_no_we", fwe, -1); check("zero_we_pulses", we_cnt - base, 0);
        check("zero_flops", o_flop_count, 0); check("zero_rd", o_mem_rd_count, 0); check("zero_wr", o_mem_wr_count, 0);

        cfg(2, 2, 2, 2, 'h100, 0, 'h6000, 1);
        pulse_start();
        steps = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (paused) begin
                check("step_pause_wr", o_mem_wr_count, steps + 1);
                if (steps == 0) begin
                    start = 1; @(negedge clk) start = 0;
                    check("step_start_ignored", paused, 1);
                end
                step = 1; @(negedge clk) step = 0;
                steps++;
                @(negedge clk) step = 1;
                @(negedge clk) step = 0;
            end else @(negedge clk);
        end
        check("step_done", done, 1); check("step_count", steps, 4);
        check("step_wr", o_mem_wr_count, 4); check("step_rd", o_mem_rd_count, 16);
        check("step_px0", dst_mem['h6000], 0); check("step_px3", dst_mem['h6003], 255);

        cfg(2, 2, 4, 4, 'h80, 0, 'h1000, 0);
        pulse_start();
        repeat (35) @(negedge clk);
        check("ab_rd2_addr", mem_raddr, 2);
        abort = 1; @(negedge clk) abort = 0;
        check("ab_busy", busy, 0); check("ab_done", done, 0); check("ab_we", mem_we, 0);
        check("ab_wr", o_mem_wr_count, 4); check("ab_flops", o_flop_count, 32); check("ab_rd", o_mem_rd_count, 16);
        cfg(2, 2, 4, 4, 'h80, 0, 'h1000, 0);
        start = 1; abort = 1; @(negedge clk) begin start = 0; abort = 0; end
        check("ab_prio_busy", busy, 0); check("ab_prio_wr", o_mem_wr_count, 4);
        pulse_start();
        check("ab_restart_clr", o_flop_count, 0); check("ab_restart_busy", busy, 1);
        for (int n = 0; n < 500 && !done; n++) @(negedge clk);
        check("ab_restart_done", done, 1); check("ab_restart_wr", o_mem_wr_count, 16);

        cfg(2, 2, 4, 4, 'h80, 0, 'h1000, 0);
        pulse_start();
        repeat (20) @(negedge clk);
        #2 rst_n = 0;
        #1 rst_n = 1;
        check("mid_rst_busy", busy, 0); check("mid_rst_raddr", mem_raddr, 0);
        check("mid_rst_wr", o_mem_wr_count, 0); check("mid_rst_wdata", mem_wdata, 0);
        base = we_cnt;
        repeat (40) @(negedge clk);
        check("mid_rst_no_we", we_cnt - base, 0); check("mid_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
